beam_direction_decoder: RTL and testbench
=========================================

# beam_direction_decoder

Front-end stage for the hall lighting system. It converts two raw IR beam-break sensors, an outer and an inner beam mounted across the doorway, into clean single-cycle `entry_pulse` / `exit_pulse` events. These pulses drive the `entry_sensor` / `exit_sensor` inputs of the occupancy counter. The block does the synchronisation, per-beam debouncing and direction decoding, and rejects aborted or reversed crossings.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles needed to accept a beam level change (1 ms at 100 MHz).
- `TIMEOUT_CYCLES`, default 200000000: maximum cycles a crossing may stay in progress before it is abandoned (2 s).
- `FAULT_CYCLES`, default 1000000000: continuous-broken duration that flags a stuck beam (10 s). Used only with `DIR_FAULT_DETECT_EN`.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset, asynchronous and active-low.
- `beam_outer` in 1: raw outer beam, 1 = broken. Asynchronous to `clk`.
- `beam_inner` in 1: raw inner beam, 1 = broken. Asynchronous to `clk`.
- `entry_pulse` out 1: one-cycle pulse for each completed outer→inner crossing.
- `exit_pulse` out 1: one-cycle pulse for each completed inner→outer crossing.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `fault` out 1: stuck-beam flag. Tied 0 when the fault feature is compiled out.

## Operation
- Each raw beam passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer's output `db_x` takes the new synchronised level only after that level has differed from `db_x` for exactly `DEBOUNCE_CYCLES` consecutive cycles.
  - Any return to the old level during that window clears the counter.
- The FSM runs on the debounced pair `{db_outer, db_inner}`. Entry path:
  - IDLE: outer only → OUT_FIRST; inner only → IN_FIRST; both in the same cycle → WAIT_CLEAR.
  - OUT_FIRST: both → BOTH_ENT; none → IDLE (aborted); inner only → WAIT_CLEAR.
  - BOTH_ENT: inner only → IN_LAST; outer only → OUT_FIRST (reversal); none → WAIT_CLEAR.
  - IN_LAST: none → IDLE, and `entry_pulse` fires; both → BOTH_ENT; outer only → WAIT_CLEAR.
- The exit path mirrors the entry path with outer and inner swapped: IN_FIRST → BOTH_EXT → OUT_LAST, and `exit_pulse` fires on the transition to IDLE.
- WAIT_CLEAR: stays until both beams are clear, then → IDLE. It never emits a pulse.
- Crossing timer:
  - Reset on every state change; counts while the FSM is not in IDLE or WAIT_CLEAR.
  - On reaching `TIMEOUT_CYCLES` the FSM goes to WAIT_CLEAR with no pulse.
- Counter width is `$clog2` of the parameter plus 1. Counters saturate and never wrap.
- `entry_pulse` and `exit_pulse` are mutually exclusive by construction. Both are registered outputs.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Synchroniser flops 0, `db_outer` = `db_inner` = 0, all counters 0.
- A raw level change that is first sampled at edge k appears on `db_x` at edge k+2+`DEBOUNCE_CYCLES`.
- A pulse is visible one cycle after the FSM transition that generates it, i.e. `DEBOUNCE_CYCLES`+3 edges after the final beam clear is first sampled.
- A pulse is high for exactly one `clk` cycle. At most one pulse is produced per crossing.
- Asserting `rst_n` mid-crossing clears everything asynchronously. No pulse is produced for that crossing.
  - After reset is released, beams that are already broken must debounce in afresh from 0.
- Minimum spacing between two pulses is 4×`DEBOUNCE_CYCLES` cycles. This is inherent to the decoding, not enforced by extra logic.

## Configuration
- `DIR_FAULT_DETECT_EN` defined:
  - A per-beam counter runs while that beam is debounced-broken.
  - When either counter reaches `FAULT_CYCLES`, `fault` is set, the FSM is forced to WAIT_CLEAR, and pulses are suppressed.
  - `fault` clears on the first cycle both debounced beams are 0, and the FSM then returns to IDLE.
- `DIR_FAULT_DETECT_EN` undefined: no fault counters are built, `fault` = 0 constantly, and `FAULT_CYCLES` is ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=50, `FAULT_CYCLES`=100, and hold each beam phase for 10 cycles.
- Outer, then both, then inner, then clear → exactly one `entry_pulse` 7 cycles after the inner beam is first sampled clear; `exit_pulse` never rises; `busy` returns to 0.
- Inner, then both, then outer, then clear → exactly one `exit_pulse`; no `entry_pulse`. Repeat twice back-to-back → two pulses.
- Outer, then both, then outer only, then clear (reversal) → no pulse; FSM back in IDLE.
- Outer pulses with 2-cycle glitches → `db_outer` never changes and `busy` stays 0. Both beams broken in the same sampled cycle → no pulse and WAIT_CLEAR until clear.
- Outer held broken for 60 cycles → timeout into WAIT_CLEAR, no pulse on release. `rst_n` low during BOTH_ENT → outputs 0 immediately and no pulse after release.
- With `DIR_FAULT_DETECT_EN`: inner held for 120 cycles → `fault`=1 at debounced-broken + 100 cycles; clearing the inner beam → `fault`=0 and no pulse.

Source files
------------

// File: rtl/beam_direction_decoder.sv
// Doorway direction decoder: sync + debounce two IR beams, emit one-cycle entry/exit pulses.
// Optional stuck-beam detection is compiled in with DIR_FAULT_DETECT_EN.
module beam_direction_decoder #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES  = 200000000,
    parameter int FAULT_CYCLES    = 1000000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beam_outer,
    input  logic beam_inner,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic busy,
    output logic fault
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LIM = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, OUT_FIRST, BOTH_ENT, IN_LAST,
        IN_FIRST, BOTH_EXT, OUT_LAST, WAIT_CLEAR
    } state_t;

    // Bit 1 = outer beam, bit 0 = inner beam throughout.
    logic [1:0]    sync1, sync2, db;
    logic [DW-1:0] db_cnt [2];
    logic [TW-1:0] tmr;
    state_t        state, state_nxt;
    logic          entry_nxt, exit_nxt;
    logic          timed, timeout, fault_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {beam_outer, beam_inner};
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == db[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] >= DB_LIM) begin
                    db[b]     <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

`ifdef DIR_FAULT_DETECT_EN
    localparam int FW = $clog2(FAULT_CYCLES) + 1;
    localparam logic [FW-1:0] F_LIM  = FW'(FAULT_CYCLES);
    localparam logic [FW-1:0] F_TRIP = FW'(FAULT_CYCLES - 1);

    logic [FW-1:0] flt_cnt [2];
    logic          trip;

    // Trip one cycle early so the flag registers exactly FAULT_CYCLES after the beam went broken.
    assign trip       = (db[1] && flt_cnt[1] >= F_TRIP) || (db[0] && flt_cnt[0] >= F_TRIP);
    assign fault_hold = trip || (fault && db != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
            fault      <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!db[b])
                    flt_cnt[b] <= '0;
                else if (flt_cnt[b] < F_LIM)
                    flt_cnt[b] <= flt_cnt[b] + 1'b1;
            end
            if (fault && db == 2'b00)
                fault <= 1'b0;
            else if (trip)
                fault <= 1'b1;
        end
    end
`else
    assign fault      = 1'b0;
    assign fault_hold = 1'b0;
`endif

    assign timed   = (state != IDLE) && (state != WAIT_CLEAR);
    assign timeout = timed && (tmr >= TO_LIM);

    always_comb begin
        state_nxt = state;
        entry_nxt = 1'b0;
        exit_nxt  = 1'b0;
        case (state)
            IDLE: case (db)
                2'b10: state_nxt = OUT_FIRST;
                2'b01: state_nxt = IN_FIRST;
                2'b11: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            OUT_FIRST: case (db)
                2'b11: state_nxt = BOTH_ENT;
                2'b00: state_nxt = IDLE;
                2'b01: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            BOTH_ENT: case (db)
                2'b01: state_nxt = IN_LAST;
                2'b10: state_nxt = OUT_FIRST;
                2'b00: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            IN_LAST: case (db)
                2'b00: begin state_nxt = IDLE; entry_nxt = 1'b1; end
                2'b11: state_nxt = BOTH_ENT;
                2'b10: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            IN_FIRST: case (db)
                2'b11: state_nxt = BOTH_EXT;
                2'b00: state_nxt = IDLE;
                2'b10: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            BOTH_EXT: case (db)
                2'b10: state_nxt = OUT_LAST;
                2'b01: state_nxt = IN_FIRST;
                2'b00: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            OUT_LAST: case (db)
                2'b00: begin state_nxt = IDLE; exit_nxt = 1'b1; end
                2'b11: state_nxt = BOTH_EXT;
                2'b01: state_nxt = WAIT_CLEAR;
                default: ;
            endcase
            WAIT_CLEAR: if (db == 2'b00) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abandoned or faulted crossings park in WAIT_CLEAR and never pulse.
        if (timeout || fault_hold) begin
            state_nxt = WAIT_CLEAR;
            entry_nxt = 1'b0;
            exit_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tmr         <= '0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_pulse <= entry_nxt;
            exit_pulse  <= exit_nxt;
            if (state_nxt != state)
                tmr <= '0;
            else if (timed && tmr < TO_LIM)
                tmr <= tmr + 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_beam_direction_decoder.sv
// Scoreboard bench for beam_direction_decoder: expected pulses are queued with their due cycle
// when the final beam clear is driven and matched by a monitor on the falling edge.
module tb_beam_direction_decoder;

    localparam int DEB = 4;
    localparam int TMO = 50;
    localparam int FLT = 100;
    localparam logic [1:0] K_ENT = 2'b10;
    localparam logic [1:0] K_EXT = 2'b01;
    localparam logic [1:0] K_NONE = 2'b00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic beam_outer = 1'b0;
    logic beam_inner = 1'b0;
    logic entry_pulse, exit_pulse, busy, fault;

    beam_direction_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .FAULT_CYCLES   (FLT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .beam_outer (beam_outer),
        .beam_inner (beam_inner),
        .entry_pulse(entry_pulse),
        .exit_pulse (exit_pulse),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic busy_seen;
    logic fault_seen = 1'b0;
    int   fault_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && fault && !fault_seen) begin
            fault_seen = 1'b1;
            fault_cyc  = cyc;
        end
        if (rst_n && (entry_pulse || exit_pulse)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, entry_pulse, exit_pulse}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", {30'd0, entry_pulse, exit_pulse}, {30'd0, e.kind});
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one beam phase from a falling edge; a completing crossing is due 8 counts later.
    task automatic phase(input logic o, input logic i, input int n, input logic [1:0] kind);
        if (kind != K_NONE) begin
            exp_t e;
            e.kind = kind;
            e.cyc  = cyc + 3 + DEB + 1;
            q.push_back(e);
        end
        beam_outer = o;
        beam_inner = i;
        repeat (n) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
    endtask

    task automatic settled(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_pending"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        busy_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_entry", entry_pulse, 0);
        chk("rst_exit", exit_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain entry crossing.
        phase(1, 0, 10, K_NONE);
        chk("entry_busy_mid", busy, 1);
        phase(1, 1, 10, K_NONE);
        phase(0, 1, 10, K_NONE);
        phase(0, 0, 20, K_ENT);
        settled("entry");

        // Two exit crossings back to back.
        for (int r = 0; r < 2; r++) begin
            phase(0, 1, 10, K_NONE);
            phase(1, 1, 10, K_NONE);
            phase(1, 0, 10, K_NONE);
            phase(0, 0, 20, K_EXT);
        end
        settled("exit2");

        // Reversal back to outer only: no pulse.
        phase(1, 0, 10, K_NONE);
        phase(1, 1, 10, K_NONE);
        phase(1, 0, 10, K_NONE);
        phase(0, 0, 20, K_NONE);
        settled("reversal");

        // Short glitches must never pass the debouncer.
        busy_seen = 1'b0;
        for (int g = 0; g < 6; g++) begin
            phase(1, 0, 2, K_NONE);
            phase(0, 0, 3, K_NONE);
        end
        phase(0, 0, 10, K_NONE);
        chk("glitch_busy_seen", busy_seen, 0);

        // Both beams together: parked in WAIT_CLEAR regardless of hold time.
        phase(1, 1, 60, K_NONE);
        chk("both_wait_busy", busy, 1);
        phase(0, 0, 20, K_NONE);
        settled("both");

        // Slow but in-time crossing still counts.
        phase(1, 0, 40, K_NONE);
        phase(1, 1, 40, K_NONE);
        phase(0, 1, 40, K_NONE);
        phase(0, 0, 20, K_ENT);
        settled("slow_ok");

        // Timeout on outer: the rest of the crossing must not complete.
        phase(1, 0, 60, K_NONE);
        chk("timeout_busy", busy, 1);
        phase(1, 1, 10, K_NONE);
        phase(0, 1, 10, K_NONE);
        phase(0, 0, 20, K_NONE);
        settled("timeout");

        // Reset mid BOTH_ENT, beams kept broken across the release.
        phase(1, 0, 10, K_NONE);
        phase(1, 1, 10, K_NONE);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_entry", entry_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_rebounce", busy, 0);
        phase(1, 1, 10, K_NONE);
        phase(0, 1, 10, K_NONE);
        phase(0, 0, 20, K_NONE);
        settled("reset");

`ifdef DIR_FAULT_DETECT_EN
        // Inner stuck: fault exactly FLT cycles after the debounced level rises.
        fault_seen = 1'b0;
        begin
            int c0;
            c0 = cyc;
            phase(0, 1, 120, K_NONE);
            chk("fault_set", fault_seen, 1);
            chk("fault_cycle", fault_cyc, c0 + 1 + 2 + DEB + FLT);
        end
        chk("fault_busy", busy, 1);
        phase(0, 0, 20, K_NONE);
        settled("fault_clear");
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
